// File: rtl/bcd2bin_arbiter.sv
// -----------------------------------------------------------------------------
// bcd2bin_arbiter
//
// Shares a single bcd2bin conversion core between two requesters. A request is
// granted round-robin, its 5-digit packed-BCD operand is screened for illegal
// digits and for values above 65535, and only clean operands are handed to the
// core. The core is driven with a start level (core_init) and must answer with
// a done level. Both the START and RELEASE phases of that handshake are
// guarded by a watchdog so a stuck core cannot lock up either requester.
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        synchronous, active-high reset
//   req0/req1    level request, held with a stable operand until ackN
//   bcd0/bcd1    packed BCD operands, digit 4 in [19:16]
//   ack0/ack1    one-cycle completion pulse to the served requester
//   result       binary value, valid while ackN is high (0 on any error)
//   err          00 ok, 01 illegal digit, 10 out of range, 11 timeout
//   busy         high whenever the arbiter is not idle
//   core_init    start level to the core
//   core_A       registered operand to the core, stable from CHECK to RESP
//   core_done    completion level from the core
//   core_result  core output, valid while core_done is high
// -----------------------------------------------------------------------------
module bcd2bin_arbiter #(
    parameter int TIMEOUT = 64  // legal range 2..65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [19:0] bcd0,
    input  logic [19:0] bcd1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] result,
    output logic [1:0]  err,
    output logic        busy,
    output logic        core_init,
    output logic [19:0] core_A,
    input  logic        core_done,
    input  logic [15:0] core_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_START,
        S_RELEASE,
        S_RESP
    } state_t;

    localparam logic [1:0]  ERR_OK      = 2'b00;
    localparam logic [1:0]  ERR_DIGIT   = 2'b01;
    localparam logic [1:0]  ERR_RANGE   = 2'b10;
    localparam logic [1:0]  ERR_TIMEOUT = 2'b11;

    // Watchdog fires when the post-increment count reaches this value.
    localparam logic [15:0] CNT_LAST    = 16'(TIMEOUT - 1);
    // Largest operand that still fits in 16 bits, as BCD digits.
    localparam logic [19:0] RANGE_LIMIT = 20'h65535;

    state_t      state_q,  state_d;
    logic        sel_q,    sel_d;
    logic        last_q,   last_d;
    logic [15:0] cnt_q,    cnt_d;
    logic [19:0] core_a_q, core_a_d;
    logic [15:0] work_q,   work_d;
    logic [15:0] result_q, result_d;
    logic [1:0]  err_q,    err_d;
    logic [1:0]  ack_q,    ack_d;

    logic        any_req;
    logic        grant_sel;
    logic        digit_bad;
    logic        over_range;
    logic [15:0] cnt_inc;
    logic        cnt_hit;

    // -------------------------------------------------------------------------
    // Operand screening on the latched operand
    // -------------------------------------------------------------------------
    // The range test is a most-significant-digit-first compare against 65535;
    // the first differing digit decides. It is only meaningful when every digit
    // is legal, which is why digit_bad takes priority in the FSM.
    always_comb begin : screen
        logic decided;
        // NOTE: every variable assigned in an always_comb gets a default before
        // any conditional assignment; otherwise synthesis infers a latch.
        digit_bad  = 1'b0;
        over_range = 1'b0;
        decided    = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (core_a_q[4*i +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
            if (!decided) begin
                if (core_a_q[4*i +: 4] > RANGE_LIMIT[4*i +: 4]) begin
                    over_range = 1'b1;
                    decided    = 1'b1;
                end else if (core_a_q[4*i +: 4] < RANGE_LIMIT[4*i +: 4]) begin
                    decided    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        any_req   = req0 | req1;
        // With both pending, serve the requester that was not served last.
        grant_sel = (req0 & req1) ? ~last_q : req1;
        cnt_inc   = cnt_q + 16'd1;
        cnt_hit   = (cnt_inc == CNT_LAST);
    end

    // -------------------------------------------------------------------------
    // State register (also holds the datapath flops)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q  <= S_IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            core_a_q <= '0;
            work_q   <= '0;
            result_q <= '0;
            err_q    <= ERR_OK;
            ack_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            core_a_q <= core_a_d;
            work_q   <= work_d;
            result_q <= result_d;
            err_q    <= err_d;
            ack_q    <= ack_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = (digit_bad || over_range) ? S_RESP : S_START;
            end
            S_START: begin
                if (core_done)    state_d = S_RELEASE;
                else if (cnt_hit) state_d = S_RESP;
            end
            S_RELEASE: begin
                if (!core_done || cnt_hit) state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next values
    // -------------------------------------------------------------------------
    // result/err are only written on the transition into RESP, so they present
    // the response during the ack cycle and then hold until the next one.
    always_comb begin
        sel_d    = sel_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        core_a_d = core_a_q;
        work_d   = work_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    sel_d    = grant_sel;
                    last_d   = grant_sel;
                    core_a_d = grant_sel ? bcd1 : bcd0;
                end
            end
            S_CHECK: begin
                if (digit_bad) begin
                    err_d    = ERR_DIGIT;
                    result_d = '0;
                end else if (over_range) begin
                    err_d    = ERR_RANGE;
                    result_d = '0;
                end
            end
            S_START: begin
                cnt_d = cnt_inc;
                if (core_done) begin
                    // Capture now; core_result is only guaranteed while done is high.
                    work_d = core_result;
                    cnt_d  = '0;
                end else if (cnt_hit) begin
                    err_d    = ERR_TIMEOUT;
                    result_d = '0;
                end
            end
            S_RELEASE: begin
                cnt_d = cnt_inc;
                if (!core_done) begin
                    err_d    = ERR_OK;
                    result_d = work_q;
                end else if (cnt_hit) begin
                    err_d    = ERR_TIMEOUT;
                    result_d = '0;
                end
            end
            S_RESP: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // The ack flop is high exactly while the FSM sits in RESP.
    always_comb begin
        ack_d = 2'b00;
        if (state_d == S_RESP) begin
            ack_d = sel_q ? 2'b10 : 2'b01;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        core_init = (state_q == S_START);
        busy      = (state_q != S_IDLE);
        ack0      = ack_q[0];
        ack1      = ack_q[1];
        result    = result_q;
        err       = err_q;
        core_A    = core_a_q;
    end

endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bcd2bin_arbiter
//
// Drives two requesters against bcd2bin_arbiter with a behavioural conversion
// core stub whose done/release delays can be varied, made to never answer, or
// made to hold done forever. Expected responses come from an arithmetic model
// of the conversion and error rules.
// -----------------------------------------------------------------------------
module tb_bcd2bin_arbiter;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [19:0] bcd0, bcd1;
    logic        ack0, ack1;
    logic [15:0] result;
    logic [1:0]  err;
    logic        busy;
    logic        core_init;
    logic [19:0] core_A;
    logic        core_done;
    logic [15:0] core_result;

    int n_checks = 0;
    int n_errors = 0;

    // Core stub controls
    int stub_dly;
    int stub_rel;
    bit stub_never;
    bit stub_stuck;
    int hi_cnt;
    int lo_cnt;

    // Observation helpers
    int init_cycles = 0;
    int ack_total   = 0;
    int order_q[$];
    bit model_last;

    bcd2bin_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .bcd0       (bcd0),
        .bcd1       (bcd1),
        .ack0       (ack0),
        .ack1       (ack1),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .core_init  (core_init),
        .core_A     (core_A),
        .core_done  (core_done),
        .core_result(core_result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bcd_val(input logic [19:0] b);
        int v = 0;
        for (int i = 4; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] b;
        int t = v;
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    // Reference: illegal digit beats range, range beats any core behaviour.
    function automatic void ref_model(input logic [19:0] b, input bit never, input bit stuck,
                                      output logic [15:0] r, output logic [1:0] e);
        bit bad = 1'b0;
        int v;
        for (int i = 0; i < 5; i++) if (b[4*i +: 4] > 4'd9) bad = 1'b1;
        v = bcd_val(b);
        r = 16'h0000;
        if (bad)                 e = 2'b01;
        else if (v > 65535)      e = 2'b10;
        else if (never || stuck) e = 2'b11;
        else begin
            e = 2'b00;
            r = 16'(v);
        end
    endfunction

    function automatic logic [19:0] gen_bcd();
        int k = int'($urandom_range(0, 9));
        if (k < 5)      return to_bcd(int'($urandom_range(0, 99999)));
        else if (k < 8) return to_bcd(int'($urandom_range(65530, 65540)));
        else            return 20'($urandom);
    endfunction

    // Behavioural core: done rises stub_dly clocks into init, falls stub_rel
    // clocks after init drops.
    always @(posedge clk) begin
        if (reset) begin
            core_done   <= 1'b0;
            core_result <= 16'hDEAD;
            hi_cnt      <= 0;
            lo_cnt      <= 0;
        end else if (core_init) begin
            lo_cnt      <= 0;
            hi_cnt      <= hi_cnt + 1;
            core_result <= 16'(bcd_val(core_A));
            if (!stub_never && hi_cnt + 1 >= stub_dly) core_done <= 1'b1;
        end else begin
            hi_cnt <= 0;
            if (core_done && !stub_stuck) begin
                lo_cnt <= lo_cnt + 1;
                if (lo_cnt + 1 >= stub_rel) core_done <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (core_init) init_cycles++;
        if (ack0 | ack1) begin
            ack_total++;
            check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
        end
    end

    // One request/ack transaction on requester n. lat = negedges from the
    // sampling edge to the first negedge at which ack is seen.
    task automatic req_txn(input int n, input logic [19:0] b, input string tag,
                           output logic [15:0] res, output logic [1:0] er, output int lat);
        logic [15:0] exp_r;
        logic [1:0]  exp_e;
        int cyc = 0;
        logic seen;
        ref_model(b, stub_never, stub_stuck, exp_r, exp_e);
        @(negedge clk);
        if (n == 0) begin bcd0 = b; req0 = 1'b1; end
        else        begin bcd1 = b; req1 = 1'b1; end
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            seen = (n == 0) ? ack0 : ack1;
        end
        check({tag, "_ack_seen"}, 32'(seen), 32'd1);
        res = result;
        er  = err;
        lat = cyc;
        check({tag, "_result"}, 32'(result), 32'(exp_r));
        check({tag, "_err"}, 32'(err), 32'(exp_e));
        check({tag, "_init_low"}, 32'(core_init), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        if (n == 0) req0 = 1'b0; else req1 = 1'b0;
        order_q.push_back(n);
        model_last = n[0];
        @(negedge clk);
        check({tag, "_ack_one_cycle"}, 32'((n == 0) ? ack0 : ack1), 32'd0);
    endtask

    logic [15:0] r0, r1;
    logic [1:0]  e0, e1;
    int lat0, lat1;
    int init_before, acks_before, cyc, got, exp_n;

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        bcd0 = '0;   bcd1 = '0;
        stub_dly = 1; stub_rel = 1;
        stub_never = 1'b0; stub_stuck = 1'b0;
        model_last = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_init", 32'(core_init), 32'd0);
        check("rst_core_A", 32'(core_A), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single request
        req_txn(0, 20'h12345, "single", r0, e0, lat0);
        check("single_value", 32'(r0), 32'h3039);
        check("single_bound", 32'(lat0 < 20), 32'd1);

        // Range boundaries
        req_txn(1, 20'h65535, "max", r1, e1, lat1);
        check("max_value", 32'(r1), 32'hFFFF);
        init_before = init_cycles;
        req_txn(1, 20'h65536, "over", r1, e1, lat1);
        check("over_err", 32'(e1), 32'd2);
        check("over_lat_cycles", 32'(lat1 + 1), 32'd3);
        check("over_no_init", 32'(init_cycles - init_before), 32'd0);
        req_txn(0, 20'h00000, "zero", r0, e0, lat0);

        // Illegal digit wins over range
        req_txn(0, 20'h1A000, "illegal", r0, e0, lat0);
        check("illegal_err", 32'(e0), 32'd1);
        check("illegal_lat_cycles", 32'(lat0 + 1), 32'd3);

        // Arbitration with both held continuously
        @(negedge clk);
        bcd0 = 20'h00010; bcd1 = 20'h00099;
        req0 = 1'b1; req1 = 1'b1;
        exp_n = model_last ? 0 : 1;
        got = 0; cyc = 0;
        while (got < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ack0 | ack1) begin
                check("arb_order", 32'(ack1), 32'(exp_n));
                check("arb_result", 32'(result), (exp_n == 1) ? 32'h0063 : 32'h000A);
                check("arb_err", 32'(err), 32'd0);
                exp_n = 1 - exp_n;
                got++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("arb_count", 32'(got), 32'd4);
        model_last = (exp_n == 0);
        @(negedge clk);

        // Timeout in START: core never answers
        stub_never = 1'b1;
        req_txn(1, 20'h00042, "tmo", r1, e1, lat1);
        check("tmo_err", 32'(e1), 32'd3);
        check("tmo_lat_cycles", 32'(lat1 + 1), 32'(TIMEOUT + 2));
        stub_never = 1'b0;
        req_txn(1, 20'h00042, "after_tmo", r1, e1, lat1);
        check("after_tmo_value", 32'(r1), 32'd42);

        // Timeout in RELEASE: done never drops
        stub_stuck = 1'b1;
        req_txn(0, 20'h00777, "stuck", r0, e0, lat0);
        check("stuck_err", 32'(e0), 32'd3);
        stub_stuck = 1'b0;
        repeat (6) @(negedge clk);

        // Reset two cycles into START
        stub_never = 1'b1;
        @(negedge clk);
        bcd0 = 20'h00777; req0 = 1'b1;
        cyc = 0;
        while (!core_init && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_start_seen", 32'(core_init), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1; req0 = 1'b0;
        @(negedge clk);
        check("rst_mid_init", 32'(core_init), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ack0", 32'(ack0), 32'd0);
        check("rst_mid_core_A", 32'(core_A), 32'd0);
        reset = 1'b0;
        model_last = 1'b1;
        stub_never = 1'b0;
        acks_before = ack_total;
        repeat (6) @(negedge clk);
        check("rst_mid_no_ack", 32'(ack_total), 32'(acks_before));

        // Both pending after reset: requester 0 is served first
        order_q.delete();
        fork
            req_txn(0, 20'h00321, "post_rst0", r0, e0, lat0);
            req_txn(1, 20'h00654, "post_rst1", r1, e1, lat1);
        join
        check("post_rst_first", 32'(order_q[0]), 32'd0);

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            stub_dly = int'($urandom_range(1, 3));
            stub_rel = int'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) begin
                fork
                    req_txn(0, gen_bcd(), "rnd_pair0", r0, e0, lat0);
                    req_txn(1, gen_bcd(), "rnd_pair1", r1, e1, lat1);
                join
            end else begin
                req_txn(int'($urandom_range(0, 1)), gen_bcd(), "rnd", r0, e0, lat0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
